vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl.sv | 146 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: x/y pixel counters, sync and blanking decode.
// Latency: counters update on the same edge as an en tick; decoded outputs are combinational from state.
// Backpressure: none; en is a pixel-rate tick and the counters simply hold while it is low.
//
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   en              - pixel tick; x/y (and frame_cnt) advance only on edges where en=1
//   x, y            - current pixel position, 0..H_TOT-1 / 0..V_TOT-1
//   hsync, vsync    - sync outputs, at level SYNC_POL while inside the sync region
//   video_on        - high while (x,y) lies in the visible area
//   line_end        - high on the tick that wraps x; frame_end on the tick that wraps x and y
//   frame_cnt       - completed-frame count, present only when FRAME_CNT_EN is defined
//
// Build option: define FRAME_CNT_EN to add the frame_cnt port and its counter.
module vga_timing_ctrl #(
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_end,
    output logic        frame_end
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // Region boundaries: each *_START is the first count of that region.
    localparam logic [9:0] H_FP_START   = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        H_ST_ACT  = 2'd0,
        H_ST_FP   = 2'd1,
        H_ST_SYNC = 2'd2,
        H_ST_BP   = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ST_ACT  = 2'd0,
        V_ST_FP   = 2'd1,
        V_ST_SYNC = 2'd2,
        V_ST_BP   = 2'd3
    } v_state_t;

    h_state_t   h_state, h_next;
    v_state_t   v_state, v_next;
    logic       x_wrap;
    logic       y_wrap;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    // Counter next values and tick pulses
    always_comb begin
        x_wrap    = (x == H_LAST);
        y_wrap    = (y == V_LAST);
        x_nxt     = x_wrap ? 10'd0 : x + 10'd1;
        y_nxt     = y_wrap ? 10'd0 : y + 10'd1;
        line_end  = en & x_wrap;
        frame_end = line_end & y_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 10'd0;
            y <= 10'd0;
        end else if (en) begin
            x <= x_nxt;
            if (x_wrap) begin
                y <= y_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state <= H_ST_ACT;
            v_state <= V_ST_ACT;
        end else begin
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    // Horizontal phase: moves on the tick whose new x is the first count of the next region.
    always_comb begin
        h_next = h_state;
        case (h_state)
            H_ST_ACT:  if (en && x_nxt == H_FP_START)   h_next = H_ST_FP;
            H_ST_FP:   if (en && x_nxt == H_SYNC_START) h_next = H_ST_SYNC;
            H_ST_SYNC: if (en && x_nxt == H_BP_START)   h_next = H_ST_BP;
            H_ST_BP:   if (en && x_wrap)                h_next = H_ST_ACT;
            default:                                    h_next = H_ST_ACT;
        endcase
    end

    // Vertical phase: same scheme, but it only steps on line wraps.
    always_comb begin
        v_next = v_state;
        case (v_state)
            V_ST_ACT:  if (line_end && y_nxt == V_FP_START)   v_next = V_ST_FP;
            V_ST_FP:   if (line_end && y_nxt == V_SYNC_START) v_next = V_ST_SYNC;
            V_ST_SYNC: if (line_end && y_nxt == V_BP_START)   v_next = V_ST_BP;
            V_ST_BP:   if (line_end && y_wrap)                v_next = V_ST_ACT;
            default:                                          v_next = V_ST_ACT;
        endcase
    end

    always_comb begin
        hsync    = (h_state == H_ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync    = (v_state == V_ST_SYNC) ? SYNC_POL : ~SYNC_POL;
        video_on = (x < H_FP_START) && (y < V_FP_START);
    end

`ifdef FRAME_CNT_EN
    // Counts completed frames; the 16-bit add wraps 65535 -> 0 naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a default-timing instance plus a small-raster, SYNC_POL=1 instance
// sharing clk/rst/en, both checked each cycle against a tick-count arithmetic model.
// The small instance makes full frames, vsync and frame_end reachable in a short run.
module tb_vga_timing_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;

    logic [9:0] x0, y0, x1, y1;
    logic       hs0, vs0, vo0, le0, fe0;
    logic       hs1, vs1, vo1, le1, fe1;
`ifdef FRAME_CNT_EN
    logic [15:0] fc0, fc1;
`endif

    int    vectors    = 0;
    int    miscompares = 0;
    int    t = 0;            // en ticks accepted since the last reset
    string cur_test = "init";

    always #5 clk = ~clk;

    vga_timing_ctrl d0 (
        .clk(clk), .rst(rst), .en(en),
        .x(x0), .y(y0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
        .line_end(le0), .frame_end(fe0)
`ifdef FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_ctrl #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1)
    ) d1 (
        .clk(clk), .rst(rst), .en(en),
        .x(x1), .y(y1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
        .line_end(le1), .frame_end(fe1)
`ifdef FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    // Expected {x, y, hsync, vsync, video_on, line_end, frame_end} after tk ticks.
    function automatic logic [24:0] model(input int tk, input logic e,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb,
                                          input logic pol);
        int   ht, vt, xx, yy;
        logic h_in, v_in, le, fe;
        ht   = hv + hf + hs + hb;
        vt   = vv + vf + vs + vb;
        xx   = tk % ht;
        yy   = (tk / ht) % vt;
        h_in = (xx >= hv + hf) && (xx < hv + hf + hs);
        v_in = (yy >= vv + vf) && (yy < vv + vf + vs);
        le   = e && (xx == ht - 1);
        fe   = le && (yy == vt - 1);
        return {10'(xx), 10'(yy), h_in ? pol : ~pol, v_in ? pol : ~pol,
                (xx < hv) && (yy < vv), le, fe};
    endfunction

    task automatic check_outputs();
        logic [24:0] exp0, exp1, got0, got1;
        exp0 = model(t, en & ~rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        exp1 = model(t, en & ~rst, 16, 2, 3, 3, 10, 2, 2, 3, 1'b1);
        got0 = {x0, y0, hs0, vs0, vo0, le0, fe0};
        got1 = {x1, y1, hs1, vs1, vo1, le1, fe1};
        vectors++;
        if (got0 !== exp0) begin
            miscompares++;
            $display("FAIL %s dut0 t=%0d {x,y,hs,vs,vo,le,fe} got=%h exp=%h", cur_test, t, got0, exp0);
        end
        vectors++;
        if (got1 !== exp1) begin
            miscompares++;
            $display("FAIL %s dut1 t=%0d {x,y,hs,vs,vo,le,fe} got=%h exp=%h", cur_test, t, got1, exp1);
        end
`ifdef FRAME_CNT_EN
        vectors++;
        if (fc0 !== 16'(t / 420000)) begin
            miscompares++;
            $display("FAIL %s dut0 frame_cnt got=%0d exp=%0d", cur_test, fc0, t / 420000);
        end
        vectors++;
        if (fc1 !== 16'(t / 408)) begin
            miscompares++;
            $display("FAIL %s dut1 frame_cnt got=%0d exp=%0d", cur_test, fc1, t / 408);
        end
`endif
    endtask

    // One clock: drive en on the falling edge, check, then account for the rising edge.
    task automatic step(input logic e);
        @(negedge clk);
        en = e;
        #1;
        check_outputs();
        @(posedge clk);
        if (e && !rst) t++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1;
        t   = 0;
        step(1'b0);
        step(1'b1);   // en during reset must not advance anything
        release_reset();
        step(1'b0);
    endtask

    task automatic test_first_line();
        cur_test = "first_line";
        for (int i = 0; i < 810; i++) step(1'b1);
    endtask

    task automatic test_frames();
        cur_test = "frames";
        for (int i = 0; i < 900; i++) step(1'b1);
    endtask

    task automatic test_toggle_en();
        cur_test = "toggle_en";
        for (int i = 0; i < 400; i++) step((i % 2) == 0);
    endtask

    task automatic test_random_en();
        cur_test = "random_en";
        for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 1)));
    endtask

    // Assert reset between clock edges and check outputs before the next rising edge.
    task automatic async_reset_now();
        #2;
        rst = 1'b1;
        t   = 0;
        #1;
        check_outputs();
        release_reset();
        step(1'b1);   // still x=0 here; first accepted tick happens on this edge
        step(1'b1);   // x=1, y=0
    endtask

    task automatic test_async_reset_midline();
        int i;
        cur_test = "async_midline";
        for (i = 0; i < 2000 && (t % 800) != 700; i++) step(1'b1);
        vectors++;
        if ((t % 800) != 700) begin
            miscompares++;
            $display("FAIL %s could not reach x=700 got_t=%0d", cur_test, t);
        end
        async_reset_now();
    endtask

    task automatic test_async_reset_midsync();
        int i;
        bit in_sync;
        cur_test = "async_midsync";
        in_sync = 1'b0;
        for (i = 0; i < 2000 && !in_sync; i++) begin
            step(1'b1);
            in_sync = ((t % 24) >= 18) && ((t % 24) <= 20) && (((t / 24) % 17) >= 12)
                      && (((t / 24) % 17) <= 13);
        end
        vectors++;
        if (!in_sync) begin
            miscompares++;
            $display("FAIL %s could not reach small-raster sync got_t=%0d", cur_test, t);
        end
        async_reset_now();
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frames();
        test_toggle_en();
        test_random_en();
        test_async_reset_midline();
        test_async_reset_midsync();
        test_random_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
